// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - N-digit multiplexed 7-segment driver; optional SEG_SCAN_LZS_EN leading-zero suppression
module seg_scan_mux #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 100000,
  parameter int DEAD_CYC   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {PH_DEAD, PH_DRIVE} phase_t;
  localparam phase_t PH_RESET = (DEAD_CYC == 0) ? PH_DRIVE : PH_DEAD;

  logic [CW-1:0]           cnt, cnt_next;
  logic [IW-1:0]           idx, idx_next;
  logic                    slot_end, frame_end;
  phase_t                  phase, phase_next;
  logic [4*NUM_DIGITS-1:0] shadow_data, active_data;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank, active_blank;
  logic                    pending;
  logic [NUM_DIGITS-1:0]   lzs_mask, eff_blank;
  logic [3:0]              nib;
  logic                    dp_sel, blank_sel, lit;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b1100000;
      4'hC:    glyph = 7'b0110001;
      4'hD:    glyph = 7'b1000010;
      4'hE:    glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign cnt_next  = slot_end ? '0 : cnt + 1'b1;
  assign idx_next  = !slot_end ? idx : ((idx == IDX_LAST) ? '0 : idx + 1'b1);

  // Prescaler and digit index advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      idx <= idx_next;
    end
  end

  // Slot phase register: tracks whether the current cnt is in dead time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= PH_RESET;
    else        phase <= phase_next;
  end

  // Next phase follows the upcoming cnt value
  always_comb begin
    phase_next = PH_DEAD;
    if ((DEAD_CYC == 0) || (cnt_next >= CNT_DEAD)) phase_next = PH_DRIVE;
  end

  // Shadow capture on load; active swap only at the frame boundary so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '1;
      active_data  <= '0;
      active_dp    <= '0;
      active_blank <= '1;
      pending      <= 1'b0;
    end else begin
      if (load) begin
        shadow_data  <= data_in;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
        pending      <= 1'b1;
      end
      if (frame_end) begin
        if (load) begin
          active_data  <= data_in;
          active_dp    <= dp_in;
          active_blank <= blank_in;
        end else if (pending) begin
          active_data  <= shadow_data;
          active_dp    <= shadow_dp;
          active_blank <= shadow_blank;
        end
        pending <= 1'b0;
      end
    end
  end

`ifdef SEG_SCAN_LZS_EN
  logic lead;

  // Darken leading zero digits from the top down; digit 0 always shows
  always_comb begin
    lzs_mask = '0;
    lead     = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (lead && (active_data[4*k +: 4] == 4'h0) && !active_dp[k]) lzs_mask[k] = 1'b1;
      else                                                            lead        = 1'b0;
    end
  end
`else
  assign lzs_mask = '0;
`endif

  assign eff_blank = active_blank | lzs_mask;

  // Select the active digit and decode the next output pattern
  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib       = active_data[4*k +: 4];
        dp_sel    = active_dp[k];
        blank_sel = eff_blank[k];
      end
    end
    lit   = (phase == PH_DRIVE) && !blank_sel;
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (lit && (idx == IW'(k))) an_d[k] = 1'b0;
    end
    if (lit) begin
      seg_d = glyph(nib);
      dp_d  = ~dp_sel;
    end
  end

  // Registered display pins and frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed table-driven bench for seg_scan_mux (4 digits, CLK_DIV=4, DEAD_CYC=1)
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_vec = 0;
  int n_err = 0;

  seg_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .DEAD_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // stimulus + per-digit expected pins; digit fields packed {d3,d2,d1,d0}
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dpi;
    logic [3:0]  blank;
    logic [15:0] an;
    logic [27:0] seg;
    logic [3:0]  dpo;
  } rec_t;

  rec_t tbl [7];
  rec_t junk, r_dark, r_3a0f, r_1111, r_2222, r_5555, r_0070, prev;

  task automatic cmp(input string name, input int p, input logic [12:0] got, input logic [12:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s p=%0d: got an/seg/dp/tick=%b_%b_%b_%b, expected %b_%b_%b_%b",
               name, p, got[12:9], got[8:2], got[1], got[0], exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  // one clock: present inputs, take the edge, check pins for slot position p of the frame
  task automatic cyc(input string name, input rec_t exp, input int p, input logic ld, input rec_t v);
    int d;
    logic [12:0] e;
    load     = ld;
    data_in  = v.data;
    dp_in    = v.dpi;
    blank_in = v.blank;
    @(posedge clk);
    @(negedge clk);
    d = p / 4;
    if (p % 4 == 0) e = {4'hF, 7'h7F, 1'b1, 1'b0};
    else            e = {exp.an[4*d +: 4], exp.seg[7*d +: 7], exp.dpo[d], 1'b0};
    e[0] = (p == 15);
    cmp(name, p, {an, seg, dp, frame_tick}, e);
  endtask

  // a full 16-cycle frame; optional loads at positions la/lb, or load held high the whole frame
  task automatic frame(input string name, input rec_t exp, input int la, input rec_t va,
                       input int lb, input rec_t vb, input bit hold);
    for (int p = 0; p < 16; p++) begin
      if (hold)         cyc(name, exp, p, 1'b1, (p == 15) ? va : junk);
      else if (p == la) cyc(name, exp, p, 1'b1, va);
      else if (p == lb) cyc(name, exp, p, 1'b1, vb);
      else              cyc(name, exp, p, 1'b0, junk);
    end
  endtask

  initial begin
    junk   = '{16'h9999, 4'b1111, 4'b0000, 16'hFFFF, {4{7'h7F}}, 4'hF};
    r_dark = '{16'h0000, 4'b0000, 4'b1111, 16'hFFFF, {4{7'h7F}}, 4'hF};
    r_3a0f = '{16'h3A0F, 4'b0100, 4'b0000, 16'h7BDE,
               {7'b0000110, 7'b0001000, 7'b0000001, 7'b0111000}, 4'b1011};
    r_1111 = '{16'h1111, 4'b0000, 4'b0000, 16'h7BDE, {4{7'b1001111}}, 4'hF};
    r_2222 = '{16'h2222, 4'b0000, 4'b0000, 16'h7BDE, {4{7'b0010010}}, 4'hF};
    r_5555 = '{16'h5555, 4'b0000, 4'b0000, 16'h7BDE, {4{7'b0100100}}, 4'hF};
`ifdef SEG_SCAN_LZS_EN
    r_0070 = '{16'h0070, 4'b0000, 4'b0000, 16'hFFDE,
               {7'h7F, 7'h7F, 7'b0001111, 7'b0000001}, 4'hF};
    tbl[2] = '{16'h0000, 4'b0010, 4'b0000, 16'hFFDE,
               {7'h7F, 7'h7F, 7'b0000001, 7'b0000001}, 4'b1101};
    tbl[3] = '{16'h0000, 4'b0000, 4'b0000, 16'hFFFE,
               {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'hF};
`else
    r_0070 = '{16'h0070, 4'b0000, 4'b0000, 16'h7BDE,
               {7'b0000001, 7'b0000001, 7'b0001111, 7'b0000001}, 4'hF};
    tbl[2] = '{16'h0000, 4'b0010, 4'b0000, 16'h7BDE, {4{7'b0000001}}, 4'b1101};
    tbl[3] = '{16'h0000, 4'b0000, 4'b0000, 16'h7BDE, {4{7'b0000001}}, 4'hF};
`endif
    tbl[0] = '{16'h8888, 4'b0000, 4'b1010, 16'hFBFE,
               {7'h7F, 7'b0000000, 7'h7F, 7'b0000000}, 4'hF};
    tbl[1] = r_0070;
    tbl[4] = '{16'h1234, 4'b0000, 4'b1111, 16'hFFFF, {4{7'h7F}}, 4'hF};
    tbl[5] = '{16'h4569, 4'b0000, 4'b0000, 16'h7BDE,
               {7'b1001100, 7'b0100100, 7'b0100000, 7'b0000100}, 4'hF};
    tbl[6] = '{16'hBCDE, 4'b1001, 4'b0000, 16'h7BDE,
               {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}, 4'b0110};

    rst_n    = 1'b0;
    load     = 1'b0;
    data_in  = junk.data;
    dp_in    = junk.dpi;
    blank_in = junk.blank;
    repeat (3) @(negedge clk);
    cmp("reset", 0, {an, seg, dp, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
    rst_n = 1'b1;

    frame("idle0", r_dark, -1, junk, -1, junk, 1'b0);
    frame("idle1", r_dark, -1, junk, -1, junk, 1'b0);
    frame("idle2", r_dark, 6, r_3a0f, -1, junk, 1'b0);
    frame("show3a0f", r_3a0f, 5, r_1111, -1, junk, 1'b0);
    frame("show1111", r_1111, 2, r_2222, 9, r_5555, 1'b0);
    prev = r_5555;
    for (int i = 0; i < 7; i++) begin
      frame($sformatf("vec%0d", i - 1), prev, (i % 2 == 1) ? 15 : 7, tbl[i], -1, junk, i == 2);
      prev = tbl[i];
    end
    frame("vec6", prev, -1, junk, -1, junk, 1'b0);

    for (int p = 0; p < 10; p++) cyc("prereset", prev, p, 1'b0, junk);
    rst_n = 1'b0;
    #1;
    cmp("async_reset", 9, {an, seg, dp, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    cmp("reset_hold", 9, {an, seg, dp, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
    rst_n = 1'b1;
    frame("post_reset", r_dark, 3, r_0070, -1, junk, 1'b0);
    frame("show0070", r_0070, -1, junk, -1, junk, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
